// File: rtl/alu_multicycle_if.sv
// Request/response bundle between the decode stage and the multicycle ALU.
// The decode stage is the master; the ALU is the slave.
interface alu_multicycle_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op_i;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result_o;
  logic [WIDTH-1:0] hi_o;
  logic             flag_zero;
  logic             flag_carry;
  logic             flag_remainder;
  logic             err_o;

  modport master (
    output in_valid, op_i, a_i, b_i, out_ready,
    input  in_ready, out_valid, result_o, hi_o,
           flag_zero, flag_carry, flag_remainder, err_o
  );

  modport slave (
    input  in_valid, op_i, a_i, b_i, out_ready,
    output in_ready, out_valid, result_o, hi_o,
           flag_zero, flag_carry, flag_remainder, err_o
  );
endinterface

// File: rtl/alu_multicycle.sv
// Multicycle ALU: single-cycle arithmetic/logic/shift ops plus iterative
// shift-add MUL and restoring DIV, valid/ready on both sides.
module alu_multicycle #(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input logic               clk,
  input logic               rst_n,
  alu_multicycle_if.slave   bus
);

  typedef enum logic [3:0] {
    OP_ADD = 4'd0, OP_SUB = 4'd1, OP_MUL = 4'd2,  OP_DIV = 4'd3,
    OP_SHL = 4'd4, OP_ROL = 4'd5, OP_SHR = 4'd6,  OP_ROR = 4'd7,
    OP_AND = 4'd8, OP_OR  = 4'd9, OP_XOR = 4'd10, OP_NOT = 4'd11
  } op_e;

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_e;

  localparam logic [SHAMT_W-1:0] CNT_INIT = SHAMT_W'(WIDTH - 1);
  localparam logic [SHAMT_W:0]   W_EXT    = (SHAMT_W + 1)'(WIDTH);

  logic [3:0]         op;
  logic [WIDTH-1:0]   a, b;
  logic [SHAMT_W-1:0] n;

  assign op = bus.op_i;
  assign a  = bus.a_i;
  assign b  = bus.b_i;
  assign n  = b[SHAMT_W-1:0];

  state_e state_q, state_d;
  logic   in_ready, accept, is_iter;

  // Iteration datapath: hi accumulates the product high half / remainder,
  // lo holds the multiplier shifting out / dividend shifting into quotient.
  logic [WIDTH-1:0]   hi_q, lo_q, opnd_q;
  logic               is_div_q;
  logic [SHAMT_W-1:0] cnt_q;

  logic [WIDTH-1:0] result_q, hi_out_q;
  logic             out_valid_q, zero_q, carry_q, rem_q, err_q;

  // ---------------- single-cycle datapath ----------------
  logic [WIDTH:0]   add_ext, sub_ext, shl_ext, shr_ext;
  logic [SHAMT_W:0] n_comp;
  logic [WIDTH-1:0] rol_val, ror_val;

  assign add_ext = {1'b0, a} + {1'b0, b};
  assign sub_ext = {1'b0, a} - {1'b0, b};
  // The extra bit catches the last bit shifted out; zero when n == 0.
  assign shl_ext = {1'b0, a} << n;
  assign shr_ext = {a, 1'b0} >> n;
  assign n_comp  = W_EXT - {1'b0, n};
  assign rol_val = (a << n) | (a >> n_comp);
  assign ror_val = (a >> n) | (a << n_comp);

  logic [WIDTH-1:0] sc_result, sc_hi;
  logic             sc_carry, sc_rem, sc_err;

  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    sc_result = '0;
    sc_hi     = '0;
    sc_carry  = 1'b0;
    sc_rem    = 1'b0;
    sc_err    = 1'b0;
    case (op)
      OP_ADD: {sc_carry, sc_result} = add_ext;
      OP_SUB: {sc_carry, sc_result} = sub_ext;
      OP_MUL: ;
      OP_DIV: begin
        if (b == '0) begin
          sc_result = '1;
          sc_hi     = a;
          sc_err    = 1'b1;
          sc_rem    = (a != '0);
        end
      end
      OP_SHL: begin
        sc_result = shl_ext[WIDTH-1:0];
        sc_carry  = shl_ext[WIDTH];
      end
      OP_SHR: begin
        sc_result = shr_ext[WIDTH:1];
        sc_carry  = shr_ext[0];
      end
      OP_ROL: sc_result = rol_val;
      OP_ROR: sc_result = ror_val;
      OP_AND: sc_result = a & b;
      OP_OR:  sc_result = a | b;
      OP_XOR: sc_result = a ^ b;
      OP_NOT: sc_result = ~a;
      default: sc_err = 1'b1;
    endcase
  end

  // ---------------- iteration step ----------------
  logic [WIDTH:0]   mul_sum, div_shift, div_diff;
  logic [WIDTH-1:0] step_hi, step_lo;

  assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
  assign div_shift = {hi_q, lo_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opnd_q};

  always_comb begin
    if (is_div_q) begin
      // Restore (keep the shifted value) when the trial subtract borrows.
      step_hi = div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
      step_lo = {lo_q[WIDTH-2:0], ~div_diff[WIDTH]};
    end else begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
    end
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && is_iter) state_d = ITER;
      ITER:    if (cnt_q == '0)       state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    is_iter  = (op == OP_MUL) || ((op == OP_DIV) && (b != '0));
    in_ready = rst_n && (state_q == IDLE) && (!out_valid_q || bus.out_ready);
    accept   = bus.in_valid && in_ready;
  end

  // ---------------- iteration registers ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hi_q     <= '0;
      lo_q     <= '0;
      opnd_q   <= '0;
      is_div_q <= 1'b0;
      cnt_q    <= '0;
    end else if (accept && is_iter) begin
      is_div_q <= (op == OP_DIV);
      opnd_q   <= (op == OP_DIV) ? b : a;
      lo_q     <= (op == OP_DIV) ? a : b;
      hi_q     <= '0;
      cnt_q    <= CNT_INIT;
    end else if (state_q == ITER) begin
      hi_q  <= step_hi;
      lo_q  <= step_lo;
      cnt_q <= cnt_q - SHAMT_W'(1);
    end
  end

  // ---------------- result registers ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      hi_out_q    <= '0;
      zero_q      <= 1'b0;
      carry_q     <= 1'b0;
      rem_q       <= 1'b0;
      err_q       <= 1'b0;
    end else if (accept && !is_iter) begin
      out_valid_q <= 1'b1;
      result_q    <= sc_result;
      hi_out_q    <= sc_hi;
      zero_q      <= (sc_result == '0);
      carry_q     <= sc_carry;
      rem_q       <= sc_rem;
      err_q       <= sc_err;
    end else if (accept) begin
      out_valid_q <= 1'b0;
    end else if (state_q == DONE) begin
      out_valid_q <= 1'b1;
      result_q    <= lo_q;
      hi_out_q    <= hi_q;
      zero_q      <= (lo_q == '0);
      carry_q     <= !is_div_q && (hi_q != '0);
      rem_q       <= is_div_q && (hi_q != '0);
      err_q       <= 1'b0;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.in_ready       = in_ready;
  assign bus.out_valid      = out_valid_q;
  assign bus.result_o       = result_q;
  assign bus.hi_o           = hi_out_q;
  assign bus.flag_zero      = zero_q;
  assign bus.flag_carry     = carry_q;
  assign bus.flag_remainder = rem_q;
  assign bus.err_o          = err_q;

endmodule
